// File: rtl/wb_router_pkg.sv
// Shared types and constants for the wishbone bus router and its watchdog.
package wb_router_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DATA_W          = 32;
   localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/wb_watchdog.sv
// Per-transaction BUSY watchdog plus a saturating count of forced completions.
module wb_watchdog
   import wb_router_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       busy_i,
   input  logic       ack_i,
   input  logic       abort_i,
   output logic       timeout_o,
   output logic [7:0] timeout_cnt_o
);

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   logic [7:0] wd_q;
   logic [7:0] wd_d;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Ack and abort both outrank expiry, so neither lets the count move.
   always_comb begin
      wd_d      = 8'd0;
      cnt_d     = cnt_q;
      timeout_o = 1'b0;
      if (busy_i) begin
         wd_d      = wd_q + 8'd1;
         timeout_o = (wd_q == WD_LAST) && !ack_i && !abort_i;
      end else begin
         wd_d      = 8'd0;
      end
      if (timeout_o && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= 8'd0;
         cnt_q <= 8'd0;
      end else begin
         wd_q  <= wd_d;
         cnt_q <= cnt_d;
      end
   end

   assign timeout_cnt_o = cnt_q;

endmodule

// File: rtl/wb_bus_router.sv
// Registered one-requester to NSLAVES-target wishbone router with unmapped-slot
// responder and per-transaction timeout watchdog.
module wb_bus_router
   import wb_router_pkg::*;
#(
   parameter int                 NSLAVES      = 4,
   parameter int                 ADDR_W       = 7,
   parameter int                 SEL_W        = 3,
   parameter int                 TIMEOUT      = DEFAULT_TIMEOUT,
   parameter logic [DATA_W-1:0]  TIMEOUT_DATA = 32'hFFFF_FFFF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_stb_i,
   input  logic                      wb_cyc_i,
   input  logic                      wb_we_i,
   input  logic [ADDR_W-1:0]         wb_adr_i,
   input  logic [DATA_W-1:0]         wb_dat_i,
   output logic [DATA_W-1:0]         wb_dat_o,
   output logic                      wb_ack_o,
   output logic [NSLAVES-1:0]        s_wb_stb_o,
   output logic [NSLAVES-1:0]        s_wb_cyc_o,
   output logic                      s_wb_we_o,
   output logic [ADDR_W-SEL_W-1:0]   s_wb_adr_o,
   output logic [DATA_W-1:0]         s_wb_dat_o,
   input  logic [NSLAVES*DATA_W-1:0] s_wb_dat_i,
   input  logic [NSLAVES-1:0]        s_wb_ack_i,
   output logic [7:0]                timeout_cnt
);

   localparam logic [SEL_W:0] NS_LIM = (SEL_W + 1)'(NSLAVES);

   state_e                    state_q, state_d;
   logic [NSLAVES-1:0]        stb_q, stb_d;
   logic                      we_q, we_d;
   logic [ADDR_W-SEL_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]         wdat_q, wdat_d;
   logic [DATA_W-1:0]         dat_q, dat_d;
   logic                      ack_q, ack_d;

   logic [SEL_W-1:0]          slot_s;
   logic                      mapped_s;
   logic [NSLAVES-1:0]        dec_s;
   logic [DATA_W-1:0]         rd_s;
   logic                      sel_ack_s;
   logic                      expired_s;

   // The registered one-hot strobe doubles as the slot select for acks and read data.
   always_comb begin
      slot_s    = wb_adr_i[ADDR_W-1 -: SEL_W];
      mapped_s  = ({1'b0, slot_s} < NS_LIM);
      dec_s     = '0;
      rd_s      = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         dec_s[i] = (slot_s == SEL_W'(i));
         if (stb_q[i]) begin
            rd_s = rd_s | s_wb_dat_i[DATA_W*i +: DATA_W];
         end else begin
            rd_s = rd_s;
         end
      end
      sel_ack_s = |(s_wb_ack_i & stb_q);
   end

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk           (clk),
      .rst           (rst),
      .busy_i        (state_q == BUSY),
      .ack_i         (sel_ack_s),
      .abort_i       (!wb_cyc_i),
      .timeout_o     (expired_s),
      .timeout_cnt_o (timeout_cnt)
   );

   // Transaction FSM: abort outranks ack, ack outranks watchdog expiry.
   always_comb begin
      state_d = state_q;
      stb_d   = stb_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      dat_d   = dat_q;
      ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (wb_stb_i && wb_cyc_i) begin
               we_d   = wb_we_i;
               adr_d  = wb_adr_i[ADDR_W-SEL_W-1:0];
               wdat_d = wb_dat_i;
               if (mapped_s) begin
                  state_d = BUSY;
                  stb_d   = dec_s;
               end else begin
                  state_d = RESP;
                  dat_d   = '0;
                  ack_d   = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (!wb_cyc_i) begin
               state_d = IDLE;
               stb_d   = '0;
            end else if (sel_ack_s) begin
               state_d = RESP;
               stb_d   = '0;
               dat_d   = rd_s;
               ack_d   = 1'b1;
            end else if (expired_s) begin
               state_d = RESP;
               stb_d   = '0;
               dat_d   = TIMEOUT_DATA;
               ack_d   = 1'b1;
            end else begin
               state_d = BUSY;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            stb_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         stb_q   <= '0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdat_q  <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
      end
   end

   assign wb_dat_o   = dat_q;
   assign wb_ack_o   = ack_q;
   assign s_wb_stb_o = stb_q;
   assign s_wb_cyc_o = stb_q;
   assign s_wb_we_o  = we_q;
   assign s_wb_adr_o = adr_q;
   assign s_wb_dat_o = wdat_q;

endmodule

// File: tb/tb_wb_bus_router.sv
// Table-driven bench for wb_bus_router with a scoreboard of expected requester acks.
module tb_wb_bus_router;

   localparam int NS = 4;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_stb_i, wb_cyc_i, wb_we_i;
   logic [6:0]    wb_adr_i;
   logic [31:0]   wb_dat_i;
   logic [31:0]   wb_dat_o;
   logic          wb_ack_o;
   logic [3:0]    s_wb_stb_o, s_wb_cyc_o;
   logic          s_wb_we_o;
   logic [3:0]    s_wb_adr_o;
   logic [31:0]   s_wb_dat_o;
   logic [127:0]  s_wb_dat_i;
   logic [3:0]    s_wb_ack_i;
   logic [7:0]    timeout_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [6:0]  adr;
      logic [31:0] wdat;
      int          tgt;
      int          ack_cyc;
      logic [31:0] rdata;
      int          stray_tgt;
      int          stray_cyc;
      logic [31:0] stray_dat;
      logic [3:0]  exp_stb;
      int          exp_ack;
      logic [31:0] exp_dat;
   } vec_t;

   typedef struct {
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[7];

   wb_bus_router #(
      .NSLAVES      (NS),
      .ADDR_W       (7),
      .SEL_W        (3),
      .TIMEOUT      (TO),
      .TIMEOUT_DATA (32'hFFFF_FFFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_stb_i    (wb_stb_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_we_i     (wb_we_i),
      .wb_adr_i    (wb_adr_i),
      .wb_dat_i    (wb_dat_i),
      .wb_dat_o    (wb_dat_o),
      .wb_ack_o    (wb_ack_o),
      .s_wb_stb_o  (s_wb_stb_o),
      .s_wb_cyc_o  (s_wb_cyc_o),
      .s_wb_we_o   (s_wb_we_o),
      .s_wb_adr_o  (s_wb_adr_o),
      .s_wb_dat_o  (s_wb_dat_o),
      .s_wb_dat_i  (s_wb_dat_i),
      .s_wb_ack_i  (s_wb_ack_i),
      .timeout_cnt (timeout_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},  {63'd0, wb_ack_o}, 64'd0);
      chk({tag, "_dato"}, {32'd0, wb_dat_o}, 64'd0);
      chk({tag, "_stb"},  {60'd0, s_wb_stb_o}, 64'd0);
      chk({tag, "_cyc"},  {60'd0, s_wb_cyc_o}, 64'd0);
      chk({tag, "_we"},   {63'd0, s_wb_we_o}, 64'd0);
      chk({tag, "_adr"},  {60'd0, s_wb_adr_o}, 64'd0);
      chk({tag, "_sdat"}, {32'd0, s_wb_dat_o}, 64'd0);
      chk({tag, "_tcnt"}, {56'd0, timeout_cnt}, 64'd0);
   endtask

   task automatic set_lanes(input vec_t v);
      for (int i = 0; i < NS; i++) begin
         if (i == v.tgt)            s_wb_dat_i[32*i +: 32] = v.rdata;
         else if (i == v.stray_tgt) s_wb_dat_i[32*i +: 32] = v.stray_dat;
         else                       s_wb_dat_i[32*i +: 32] = 32'h5A5A_5A50 | 32'(i);
      end
   endtask

   // Runs one transaction; starts and ends at a negedge with the router idle.
   task automatic run_txn(input vec_t v);
      int   n;
      bit   done;
      exp_t e;
      set_lanes(v);
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      wb_we_i  = v.we;
      wb_adr_i = v.adr;
      wb_dat_i = v.wdat;
      sb_q.push_back('{dat: v.exp_dat, cyc: v.exp_ack});
      n    = 0;
      done = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         s_wb_ack_i = 4'b0000;
         if (wb_ack_o) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_ack", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("ack_cycle", 64'(n), 64'(e.cyc));
               chk("ack_data", {32'd0, wb_dat_o}, {32'd0, e.dat});
            end
            chk("stb_dropped", {60'd0, s_wb_stb_o}, 64'd0);
            chk("latched_we",  {63'd0, s_wb_we_o}, {63'd0, v.we});
            chk("latched_adr", {60'd0, s_wb_adr_o}, {60'd0, v.adr[3:0]});
            chk("latched_dat", {32'd0, s_wb_dat_o}, {32'd0, v.wdat});
            wb_stb_i = 1'b0;
            wb_cyc_i = 1'b0;
            done     = 1'b1;
         end else begin
            chk("tgt_stb", {60'd0, s_wb_stb_o}, (n < v.exp_ack) ? {60'd0, v.exp_stb} : 64'd0);
            chk("tgt_cyc", {60'd0, s_wb_cyc_o}, (n < v.exp_ack) ? {60'd0, v.exp_stb} : 64'd0);
            if (n == v.ack_cyc && v.tgt >= 0)         s_wb_ack_i = s_wb_ack_i | (4'b0001 << v.tgt);
            if (n == v.stray_cyc && v.stray_tgt >= 0) s_wb_ack_i = s_wb_ack_i | (4'b0001 << v.stray_tgt);
         end
      end
      if (!done) begin
         chk("ack_wait_expired", 64'(n), 64'(v.exp_ack));
         void'(sb_q.pop_front());
         wb_stb_i   = 1'b0;
         wb_cyc_i   = 1'b0;
         s_wb_ack_i = 4'b0000;
      end
      @(negedge clk);
      chk("ack_one_cycle", {63'd0, wb_ack_o}, 64'd0);
   endtask

   initial begin
      // we adr wdat tgt ackcyc rdata stray_tgt stray_cyc stray_dat exp_stb exp_ack exp_dat
      vecs[0] = '{1'b0, 7'h25, 32'h0000_0000, 2, 4,  32'hCAFE_0002, -1, 0, 32'h0, 4'b0100, 5,  32'hCAFE_0002};
      vecs[1] = '{1'b1, 7'h03, 32'h1234_5678, 0, 1,  32'h0000_0A0A, -1, 0, 32'h0, 4'b0001, 2,  32'h0000_0A0A};
      vecs[2] = '{1'b0, 7'h60, 32'h0000_0000, -1, 0, 32'h0,         -1, 0, 32'h0, 4'b0000, 1,  32'h0000_0000};
      vecs[3] = '{1'b0, 7'h1A, 32'h0000_0000, 1, 0,  32'h0000_1111, -1, 0, 32'h0, 4'b0010, TO + 1, 32'hFFFF_FFFF};
      vecs[4] = '{1'b0, 7'h3F, 32'h0000_0000, 3, 5,  32'h0000_3333, 1, 2, 32'h0000_0BAD, 4'b1000, 6, 32'h0000_3333};
      vecs[5] = '{1'b1, 7'h7F, 32'hA5A5_0007, -1, 0, 32'h0,         -1, 0, 32'h0, 4'b0000, 1,  32'h0000_0000};
      vecs[6] = '{1'b0, 7'h11, 32'h0000_0000, 1, TO, 32'h1515_0001, -1, 0, 32'h0, 4'b0010, TO + 1, 32'h1515_0001};

      rst        = 1'b1;
      wb_stb_i   = 1'b0;
      wb_cyc_i   = 1'b0;
      wb_we_i    = 1'b0;
      wb_adr_i   = 7'h00;
      wb_dat_i   = 32'h0;
      s_wb_dat_i = {4{32'hDEAD_BEEF}};
      s_wb_ack_i = 4'b0000;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i]);
      end
      chk("tcnt_after_vectors", {56'd0, timeout_cnt}, 64'd1);

      for (int i = 0; i < 253; i++) begin
         run_txn(vecs[3]);
      end
      chk("tcnt_254", {56'd0, timeout_cnt}, 64'd254);
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[3]);
      end
      chk("tcnt_saturated", {56'd0, timeout_cnt}, 64'd255);

      // Abort in the second BUSY cycle, with a coincident target ack that must lose.
      set_lanes(vecs[0]);
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      wb_we_i  = 1'b0;
      wb_adr_i = 7'h22;
      @(negedge clk);
      chk("abort_stb_c1", {60'd0, s_wb_stb_o}, 64'h4);
      @(negedge clk);
      chk("abort_stb_c2", {60'd0, s_wb_stb_o}, 64'h4);
      wb_stb_i   = 1'b0;
      wb_cyc_i   = 1'b0;
      s_wb_ack_i = 4'b0100;
      @(negedge clk);
      s_wb_ack_i = 4'b0000;
      chk("abort_stb_dropped", {60'd0, s_wb_stb_o}, 64'd0);
      chk("abort_no_ack", {63'd0, wb_ack_o}, 64'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("abort_quiet_ack", {63'd0, wb_ack_o}, 64'd0);
      end
      chk("abort_tcnt", {56'd0, timeout_cnt}, 64'd255);
      chk("abort_sb_empty", 64'(sb_q.size()), 64'd0);
      run_txn(vecs[0]);

      // Synchronous reset in the middle of BUSY.
      set_lanes(vecs[6]);
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      wb_adr_i = 7'h10;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_stb", {60'd0, s_wb_stb_o}, 64'h2);
      rst      = 1'b1;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      @(negedge clk);
      chk_all_zero("mid_reset");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_quiet_ack", {63'd0, wb_ack_o}, 64'd0);
      end
      run_txn(vecs[4]);
      chk("final_tcnt", {56'd0, timeout_cnt}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
